// File: rtl/alu_seq_ext.sv
// Execute-stage ALU: single-cycle base RV32I ops plus iterative RV32M multiply/divide
// behind a valid/ready handshake; results are registered and pulsed on out_valid.
module alu_seq_ext #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            op5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  LAST_CNT = SHW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state;
    logic [SHW-1:0] cnt;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] base_op(input logic [2:0] f3, input logic sub,
                                                input logic arith,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic signed [XLEN-1:0] sr;
        logic [SHW-1:0]         sh;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        sr = sa >>> sh;
        case (f3)
            3'b000:  return sub ? a - b : a + b;
            3'b001:  return a << sh;
            3'b010:  return {{(XLEN-1){1'b0}}, sa < sb};
            3'b011:  return {{(XLEN-1){1'b0}}, a < b};
            3'b100:  return a ^ b;
            3'b101:  return arith ? sr : a >> sh;
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    logic            is_m, is_mul, m_sa, m_sb, div_signed;
    logic            sign_a, sign_b, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, base_res, special_res, idle_res;

    always_comb begin
        is_m       = (ENABLE_M != 0) && (aluop == 2'b10) && op5 && funct7_0;
        is_mul     = is_m && !funct3[2];
        m_sa       = (funct3 == 3'b001) || (funct3 == 3'b010);
        m_sb       = (funct3 == 3'b001);
        div_signed = !funct3[0];
        sign_a     = is_mul ? (m_sa & src_a[XLEN-1]) : (div_signed & src_a[XLEN-1]);
        sign_b     = is_mul ? (m_sb & src_b[XLEN-1]) : (div_signed & src_b[XLEN-1]);
        mag_a      = neg_if(src_a, sign_a);
        mag_b      = neg_if(src_b, sign_b);
        // Divide-by-zero and MIN/-1 never iterate; their results are fixed by the ISA
        div_zero   = (src_b == '0);
        div_ovf    = div_signed && (src_a == MIN_VAL) && (src_b == '1);
        special    = is_m && funct3[2] && (div_zero || div_ovf);
        if (div_zero) special_res = funct3[1] ? src_a : '1;
        else          special_res = funct3[1] ? '0 : MIN_VAL;
        case (aluop)
            2'b01:   base_res = src_a - src_b;
            2'b10:   base_res = base_op(funct3, op5 & funct7_5, funct7_5, src_a, src_b);
            default: base_res = src_a + src_b;
        endcase
        idle_res = is_m ? special_res : base_res;
    end

    logic [XLEN-1:0]   mcand, quo, rem_r, divisor;
    logic [2*XLEN-1:0] acc;
    logic              neg_q, neg_r;
    logic [2:0]        fn;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_next, prod;
    logic              div_ge, last;
    logic [XLEN-1:0]   rem_next, quo_next, mul_res, div_res, iter_res;

    always_comb begin
        // Shift-add: low half of acc holds the remaining multiplier bits
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next  = {mul_sum, acc[XLEN-1:1]};
        prod      = neg_q ? -acc_next : acc_next;
        mul_res   = (fn == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        // Restoring step: borrow out of the trial subtract means "does not fit"
        div_shift = {rem_r, quo[XLEN-1]};
        div_diff  = div_shift - {1'b0, divisor};
        div_ge    = !div_diff[XLEN];
        rem_next  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_next  = {quo[XLEN-2:0], div_ge};
        div_res   = fn[1] ? neg_if(rem_next, neg_r) : neg_if(quo_next, neg_q);
        iter_res  = (state == MUL) ? mul_res : div_res;
        last      = (cnt == LAST_CNT);
    end

    assign in_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        if (is_mul) begin
                            state <= MUL;
                        end else if (is_m && !special) begin
                            state <= DIV;
                        end else begin
                            result    <= idle_res;
                            zero      <= (idle_res == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result    <= iter_res;
                        zero      <= (iter_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/working registers carry no reset; they are always loaded on accept
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            mcand   <= mag_a;
            acc     <= {{XLEN{1'b0}}, mag_b};
            quo     <= mag_a;
            rem_r   <= '0;
            divisor <= mag_b;
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            fn      <= funct3;
        end else if (state == MUL) begin
            acc <= acc_next;
        end else if (state == DIV) begin
            quo   <= quo_next;
            rem_r <= rem_next;
        end
    end
endmodule

// File: tb/tb_alu_seq_ext.sv
// Randomized and directed checks of alu_seq_ext against an arithmetic reference model,
// with one instance built with the M extension and one without.
module tb_alu_seq_ext;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_m, in_valid_n;
    logic        rdy_m, rdy_n, ov_m, ov_n, zero_m, zero_n;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic        f75, f70, op5;
    logic [31:0] a, b, res_m, res_n;

    int n_chk  = 0;
    int n_fail = 0;
    bit sel_n  = 1'b0;

    logic        rdy, ov, zr;
    logic [31:0] res;
    assign rdy = sel_n ? rdy_n  : rdy_m;
    assign ov  = sel_n ? ov_n   : ov_m;
    assign zr  = sel_n ? zero_n : zero_m;
    assign res = sel_n ? res_n  : res_m;

    always #5 clk = ~clk;

    alu_seq_ext #(.XLEN(32), .ENABLE_M(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_ready(rdy_m),
        .aluop(aluop), .funct3(funct3), .funct7_5(f75), .funct7_0(f70), .op5(op5),
        .src_a(a), .src_b(b), .out_valid(ov_m), .result(res_m), .zero(zero_m)
    );

    alu_seq_ext #(.XLEN(32), .ENABLE_M(0)) dut_nm (
        .clk(clk), .reset(reset), .in_valid(in_valid_n), .in_ready(rdy_n),
        .aluop(aluop), .funct3(funct3), .funct7_5(f75), .funct7_0(f70), .op5(op5),
        .src_a(a), .src_b(b), .out_valid(ov_n), .result(res_n), .zero(zero_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_special_div(input logic [2:0] f3, input logic [31:0] va,
                                          input logic [31:0] vb);
        return (vb == 32'd0) || (!f3[0] && va == 32'h8000_0000 && vb == 32'hFFFF_FFFF);
    endfunction

    function automatic int model_lat(input bit en_m, input logic [1:0] ao, input logic [2:0] f3,
                                     input logic v70, input logic vop5,
                                     input logic [31:0] va, input logic [31:0] vb);
        if (!(en_m && ao == 2'b10 && vop5 && v70)) return 1;
        if (!f3[2]) return 33;
        return is_special_div(f3, va, vb) ? 1 : 33;
    endfunction

    function automatic logic [31:0] model(input bit en_m, input logic [1:0] ao,
                                          input logic [2:0] f3, input logic v75,
                                          input logic v70, input logic vop5,
                                          input logic [31:0] va, input logic [31:0] vb);
        longint             sa, sb;
        logic [63:0]        p;
        logic signed [31:0] t;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        if (ao == 2'b01) return va - vb;
        if (ao != 2'b10) return va + vb;
        if (en_m && vop5 && v70) begin
            case (f3)
                3'd0: begin p = sa * sb; return p[31:0]; end
                3'd1: begin p = sa * sb; return p[63:32]; end
                3'd2: begin p = sa * longint'({32'd0, vb}); return p[63:32]; end
                3'd3: begin p = {32'd0, va} * {32'd0, vb}; return p[63:32]; end
                3'd4: begin
                    if (vb == 0) return 32'hFFFF_FFFF;
                    if (is_special_div(f3, va, vb)) return 32'h8000_0000;
                    return 32'(sa / sb);
                end
                3'd5: return (vb == 0) ? 32'hFFFF_FFFF : va / vb;
                3'd6: begin
                    if (vb == 0) return va;
                    if (is_special_div(f3, va, vb)) return 32'd0;
                    return 32'(sa % sb);
                end
                default: return (vb == 0) ? va : va % vb;
            endcase
        end
        case (f3)
            3'd0: return (vop5 && v75) ? va - vb : va + vb;
            3'd1: return va << vb[4:0];
            3'd2: return ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            3'd3: return (va < vb) ? 32'd1 : 32'd0;
            3'd4: return va ^ vb;
            3'd5: begin
                t = $signed(va) >>> vb[4:0];
                return v75 ? t : va >> vb[4:0];
            end
            3'd6: return va | vb;
            default: return va & vb;
        endcase
    endfunction

    task automatic run_op(input bit nm, input logic [1:0] ao, input logic [2:0] f3,
                          input logic v75, input logic v70, input logic vop5,
                          input logic [31:0] va, input logic [31:0] vb);
        logic [31:0] exp;
        int          exp_lat, lat, waited;
        bit          busy_ok;
        sel_n   = nm;
        exp     = model(!nm, ao, f3, v75, v70, vop5, va, vb);
        exp_lat = model_lat(!nm, ao, f3, v70, vop5, va, vb);
        @(negedge clk);
        waited = 0;
        while (!rdy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy) begin
            chk("ready_timeout", 32'(rdy), 32'd1);
            return;
        end
        aluop = ao; funct3 = f3; f75 = v75; f70 = v70; op5 = vop5; a = va; b = vb;
        if (nm) in_valid_n = 1'b1;
        else    in_valid_m = 1'b1;
        @(posedge clk);
        #1;
        in_valid_m = 1'b0;
        in_valid_n = 1'b0;
        // Scramble inputs after accept: the latched operation must be unaffected
        a = $urandom; b = $urandom; funct3 = 3'($urandom); aluop = 2'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (rdy) busy_ok = 1'b0;
        end while (!ov && lat < 100);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", res, exp);
        chk("zero", 32'(zr), 32'(exp == 32'd0));
        chk("busy_ready_low", 32'(busy_ok), 32'd1);
        @(negedge clk);
        chk("pulse_one_cycle", 32'(ov), 32'd0);
        chk("ready_after_done", 32'(rdy), 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int          pulses;
        bit          saw_pulse;
        logic [31:0] ra, rb;
        reset = 1'b1;
        in_valid_m = 1'b0; in_valid_n = 1'b0;
        aluop = 2'b00; funct3 = 3'b000; f75 = 1'b0; f70 = 1'b0; op5 = 1'b0;
        a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(rdy_m), 32'd0);
        chk("reset_out_valid", 32'(ov_m), 32'd0);
        chk("reset_result", res_m, 32'd0);
        chk("reset_zero", 32'(zero_m), 32'd1);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(rdy_m), 32'd1);
        chk("ready_after_reset_nm", 32'(rdy_n), 32'd1);

        // Directed cases
        run_op(0, 2'b10, 3'b000, 1, 0, 1, 32'd5, 32'd7);
        run_op(0, 2'b10, 3'b000, 1, 0, 0, 32'd5, 32'd7);
        run_op(0, 2'b10, 3'b101, 1, 0, 1, 32'h8000_0000, 32'd4);
        run_op(0, 2'b10, 3'b101, 0, 0, 1, 32'h8000_0000, 32'd4);
        run_op(0, 2'b10, 3'b011, 0, 0, 1, 32'd1, 32'hFFFF_FFFF);
        run_op(0, 2'b10, 3'b001, 0, 1, 1, 32'hFFFF_FFFF, 32'd2);
        run_op(0, 2'b10, 3'b011, 0, 1, 1, 32'hFFFF_FFFF, 32'd2);
        run_op(0, 2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFF9, 32'd2);
        run_op(0, 2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFF9, 32'd2);
        run_op(0, 2'b10, 3'b101, 0, 1, 1, 32'd7, 32'd0);
        run_op(0, 2'b10, 3'b100, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(0, 2'b10, 3'b110, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(0, 2'b01, 3'b000, 0, 0, 0, 32'd0, 32'd1);
        run_op(0, 2'b11, 3'b000, 0, 0, 0, 32'hFFFF_FFFF, 32'd1);
        run_op(1, 2'b10, 3'b000, 0, 1, 1, 32'd3, 32'd4);

        // Randomized operations against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            run_op(($urandom_range(0, 3) == 0), 2'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   ra, rb);
        end

        // Back-to-back requests on the base-only instance: ready drops exactly while busy
        sel_n = 1'b1;
        @(negedge clk);
        aluop = 2'b00; funct3 = 3'b000; a = 32'd10; b = 32'd20;
        in_valid_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov) pulses++;
            chk("b2b_ready_vs_busy", 32'(rdy), 32'(!ov));
        end
        in_valid_n = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd4);
        chk("b2b_result", res, 32'd30);
        @(negedge clk);

        // Reset in the middle of a long divide
        sel_n = 1'b0;
        @(negedge clk);
        aluop = 2'b10; funct3 = 3'b100; f70 = 1'b1; op5 = 1'b1; f75 = 1'b0;
        a = 32'd100000; b = 32'd3;
        in_valid_m = 1'b1;
        @(posedge clk);
        #1 in_valid_m = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        saw_pulse = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ov) saw_pulse = 1'b1;
        end
        chk("mid_reset_ready", 32'(rdy), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy), 32'd1);
        chk("abort_result", res, 32'd0);
        chk("abort_zero", 32'(zr), 32'd1);
        repeat (40) begin
            @(negedge clk);
            if (ov) saw_pulse = 1'b1;
        end
        chk("abort_no_pulse", 32'(saw_pulse), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_ext.md
# alu_seq_ext

Parametrised, multi-cycle successor to the single-cycle ALU decode path for the RISC-V core. It combines operation decode (ALUOp/funct3/funct7/op) with execution, and adds the RV32M multiply/divide group as iterative operations behind a valid/ready handshake. Base integer operations complete in one registered cycle; MUL*/DIV*/REM* take XLEN+1 cycles. The block sits in the execute stage and stalls the pipeline through `in_ready`.

## Interface
Parameters:
- XLEN, 32, operand/result width (≥8, power of two)
- ENABLE_M, 1, 1 = decode and execute RV32M; 0 = funct7[0] ignored, base decode only

Ports (single clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; high only in IDLE
- aluop  in  2  00 add, 01 sub, 10 funct-decoded, 11 reserved (add)
- funct3  in  3  instruction funct3
- funct7_5  in  1  instruction bit 30
- funct7_0  in  1  instruction bit 25 (M-ext select)
- op5  in  1  opcode bit 5 (1 = R-type)
- src_a, src_b  in  XLEN  operands
- out_valid  out  1  one-cycle pulse, result valid
- result  out  XLEN  held until next out_valid
- zero  out  1  result == 0, registered with result

## Operation
- Accept = in_valid & in_ready; operands and decoded op latched on accept.
- Decode with aluop=10 and NOT M-ext: funct3 000 add, or sub if op5&funct7_5; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra if funct7_5; 110 or; 111 and. Shift amount = src_b[log2(XLEN)-1:0].
- M-ext = ENABLE_M & aluop==10 & op5 & funct7_0. funct3: 000 mul (low), 001 mulh (s×s), 010 mulhsu (s×u), 011 mulhu (u×u), 100 div, 101 divu, 110 rem, 111 remu.
- Arithmetic: add/sub wrap modulo 2^XLEN. Multiply forms 2·XLEN-bit product by shift-add on magnitudes, negated if operand signs differ (signed forms only). Divide is restoring, on magnitudes; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
- Special cases, resolved at accept without iteration (latency 1): divisor 0 -> quotient all ones, remainder = src_a; signed MIN / −1 -> quotient MIN, remainder 0.
- FSM: IDLE -> (base op or special case) DONE; IDLE -> (mul) MUL; IDLE -> (div/rem) DIV; MUL/DIV run counter 0..XLEN-1, then DONE; DONE -> IDLE, asserting out_valid that cycle.

## Timing
- Reset values: in_ready 0 during reset, 1 in first cycle after deassert; out_valid 0; result 0; zero 1; state IDLE; counter 0.
- Base op accepted at edge N: out_valid high cycle N+1, in_ready low cycle N+1, next accept edge N+2.
- MUL/DIV accepted at edge N: iteration edges N+1..N+XLEN, out_valid high cycle N+XLEN+1.
- in_valid while in_ready=0 is ignored; upstream holds it.
- No output backpressure: out_valid is a single-cycle pulse; consumer must capture.
- Reset mid-operation: asynchronous abort to IDLE, no out_valid, partial result discarded.
- Operand inputs changing after accept have no effect.

## Test plan
- Reset asserted mid-DIV at iteration 10 -> out_valid never pulses, in_ready=1 first cycle after release, result=0, zero=1.
- aluop=10, funct3=000, op5=1, funct7_5=1, a=5, b=7 -> result 0xFFFFFFFE, out_valid one cycle after accept; same with op5=0 -> result 12.
- funct3=101, funct7_5=1, a=0x80000000, b=4 -> 0xF8000000; funct7_5=0 -> 0x08000000; funct3=011, a=1, b=0xFFFFFFFF -> 1.
- M-ext mulh, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF; mulhu same operands -> 0x00000001; out_valid exactly 33 cycles after accept.
- div a=−7, b=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu a=7, b=0 -> 0xFFFFFFFF in 1 cycle; div a=0x80000000, b=−1 -> 0x80000000, rem -> 0.
- ENABLE_M=0: funct7_0=1, funct3=000, a=3, b=4 -> add 7, latency 1; back-to-back in_valid shows in_ready low exactly during busy cycles.
